tx_packet_ctrl: RTL and testbench

Transmit packet sequencer for the USB device datapath. It accepts a one-cycle packet request and drives the packet-combiner select lines. For DATA packets it starts and waits on the encryption engine and then the CRC16 unit, and tracks the DATA0/DATA1 toggle. It pulses a load into the transmit shift register with the byte count, then holds the selection until the serializer reports completion.

---
 rtl/usb_tx_pkg.sv | 49 ++++
 rtl/timeout_cnt.sv | 27 ++
 rtl/tx_packet_ctrl.sv | 123 ++++++++++++
 tb/tb_tx_packet_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared constants and types for the USB transmit datapath: PIDs, packet
// types, combiner select codes and the packet sequencer state encoding.
package usb_tx_pkg;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_SOF   = 8'hA5;

  typedef enum logic [1:0] {
    PKT_TOKEN     = 2'd0,
    PKT_DATA      = 2'd1,
    PKT_HANDSHAKE = 2'd2,
    PKT_SOF       = 2'd3
  } pkt_type_t;

  localparam logic [2:0] SEL_TOKEN     = 3'b000;
  localparam logic [2:0] SEL_DATA      = 3'b001;
  localparam logic [2:0] SEL_HANDSHAKE = 3'b010;
  localparam logic [2:0] SEL_SOF       = 3'b011;
  localparam logic [2:0] SEL_IDLE      = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ENC  = 3'd1,
    ST_CRC  = 3'd2,
    ST_LOAD = 3'd3,
    ST_SEND = 3'd4
  } ctrl_state_t;

  function automatic logic [3:0] bytes_of(input pkt_type_t t);
    case (t)
      PKT_DATA:      return 4'd11;
      PKT_HANDSHAKE: return 4'd1;
      default:       return 4'd3;
    endcase
  endfunction

  function automatic logic [2:0] sel_of(input pkt_type_t t);
    case (t)
      PKT_TOKEN:     return SEL_TOKEN;
      PKT_DATA:      return SEL_DATA;
      PKT_HANDSHAKE: return SEL_HANDSHAKE;
      default:       return SEL_SOF;
    endcase
  endfunction

endpackage

// File: rtl/timeout_cnt.sv
// Wait-cycle counter: synchronous clear, count enable, and a terminal flag
// raised when the count reaches TIMEOUT-1.
module timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] TERM = W'(TIMEOUT - 1);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state is only ever assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_term = (r_cnt == TERM);

endmodule

// File: rtl/tx_packet_ctrl.sv
// Transmit packet sequencer: steps a request through encryption and CRC (DATA
// only), loads the shift register and holds the combiner select until tx_done.
module tx_packet_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] pkt_type,
  input  logic [7:0] pid_in,
  input  logic       ack_rx,
  input  logic       enc_done,
  input  logic       crc_done,
  input  logic       tx_done,
  output logic       enc_start,
  output logic       crc_start,
  output logic [2:0] data_sel,
  output logic [7:0] pid_out,
  output logic       load,
  output logic [3:0] byte_count,
  output logic       busy,
  output logic       done,
  output logic       err
);

  import usb_tx_pkg::*;

  ctrl_state_t r_state;
  ctrl_state_t w_next;
  pkt_type_t   r_type;
  logic [7:0]  r_pid;
  logic [3:0]  r_bytes;
  logic        r_toggle;
  logic        r_first;
  logic        r_done;
  logic        r_err;
  logic        w_term;
  logic        w_timeout;
  logic        w_finish;
  logic        w_cnt_clr;
  logic        w_cnt_en;
  logic        w_accept;
  logic        w_tog_now;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_next = (pkt_type_t'(pkt_type) == PKT_DATA) ? ST_ENC : ST_LOAD;
      ST_ENC: begin
        if (enc_done)    w_next = ST_CRC;
        else if (w_term) begin w_next = ST_IDLE; w_timeout = 1'b1; end
      end
      ST_CRC: begin
        if (crc_done)    w_next = ST_LOAD;
        else if (w_term) begin w_next = ST_IDLE; w_timeout = 1'b1; end
      end
      ST_LOAD: w_next = ST_SEND;
      ST_SEND: if (tx_done) begin w_next = ST_IDLE; w_finish = 1'b1; end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_tog_now = r_toggle ^ ack_rx;
  assign w_cnt_en  = (r_state == ST_ENC) || (r_state == ST_CRC);
  assign w_cnt_clr = (w_next != r_state) && ((w_next == ST_ENC) || (w_next == ST_CRC));

  timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .o_term (w_term)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_first  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_toggle <= 1'b0;
      r_type   <= PKT_TOKEN;
      r_pid    <= 8'h00;
      r_bytes  <= 4'd0;
    end else begin
      r_state <= w_next;
      r_first <= (w_next != r_state);
      r_done  <= w_finish;
      r_err   <= w_timeout;
      if (ack_rx) r_toggle <= ~r_toggle;
      // DATA PID uses the toggle as it will be after a coincident ack_rx.
      if (w_accept) begin
        r_type  <= pkt_type_t'(pkt_type);
        r_bytes <= bytes_of(pkt_type_t'(pkt_type));
        if (pkt_type_t'(pkt_type) == PKT_DATA) r_pid <= w_tog_now ? PID_DATA1 : PID_DATA0;
        else                                  r_pid <= pid_in;
      end
    end
  end

  always_comb begin
    data_sel = SEL_IDLE;
    case (r_state)
      ST_CRC:           data_sel = SEL_DATA;
      ST_LOAD, ST_SEND: data_sel = sel_of(r_type);
      default:          data_sel = SEL_IDLE;
    endcase
  end

  assign enc_start  = (r_state == ST_ENC) && r_first;
  assign crc_start  = (r_state == ST_CRC) && r_first;
  assign load       = (r_state == ST_LOAD);
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign err        = r_err;
  assign pid_out    = r_pid;
  assign byte_count = r_bytes;

endmodule

// File: tb/tb_tx_packet_ctrl.sv
// Self-checking bench for tx_packet_ctrl: directed table, hand sequences for
// reset/stray strobes, and randomized packets against a timeline model.
module tb_tx_packet_ctrl;

  import usb_tx_pkg::*;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] pkt_type = 2'd0;
  logic [7:0] pid_in = 8'h00;
  logic       ack_rx = 1'b0;
  logic       enc_done = 1'b0;
  logic       crc_done = 1'b0;
  logic       tx_done = 1'b0;
  logic       enc_start, crc_start, load, busy, done, err;
  logic [2:0] data_sel;
  logic [7:0] pid_out;
  logic [3:0] byte_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_toggle = 1'b0;

  tx_packet_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .pkt_type(pkt_type), .pid_in(pid_in),
    .ack_rx(ack_rx), .enc_done(enc_done), .crc_done(crc_done), .tx_done(tx_done),
    .enc_start(enc_start), .crc_start(crc_start), .data_sel(data_sel),
    .pid_out(pid_out), .load(load), .byte_count(byte_count), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ty;
    logic [7:0] pid;
    int         e;
    int         c;
    int         t;
    bit         ack_with;
    bit         stray_sof;
    int         gap;
    bit         gap_ack;
    logic [7:0] exp_pid;
    logic [3:0] exp_bytes;
    logic [2:0] exp_sel;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] obs();
    return {busy, enc_start, crc_start, load, done, err, data_sel};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 1'b0; ack_rx = 1'b0; enc_done = 1'b0; crc_done = 1'b0; tx_done = 1'b0;
  endtask

  task automatic idle(input int n, input bit ack_first);
    for (int k = 0; k < n; k++) begin
      clear_inputs();
      if (ack_first && k == 0) begin
        ack_rx = 1'b1;
        model_toggle = ~model_toggle;
      end
      tick();
      check("idle outputs", 32'(obs()), 32'({6'b0, SEL_IDLE}));
    end
    clear_inputs();
  endtask

  // Expected timeline is derived from the request and the strobe delays:
  // e/c are cycles from each start pulse to its done strobe, t from SEND entry.
  task automatic run_packet(input logic [1:0] ty, input logic [7:0] pid, input int e, input int c,
                            input int t, input bit ack_with, input bit noise, input bit stray_sof,
                            input logic [7:0] exp_pid, input logic [3:0] exp_bytes,
                            input logic [2:0] exp_sel);
    bit is_data = (ty == 2'd1);
    int crc0 = -1, load_c = -1, send_c = -1, tx_c = -1, done_c = -1, err_c = -1;
    int enc_done_c = -1, crc_done_c = -1, endc;
    bit in_enc, in_crc, in_send, sel_on;
    logic [8:0] ev;
    if (!is_data) begin
      load_c = 1; send_c = 2; tx_c = 2 + t; done_c = tx_c + 1;
    end else if (e > TO - 1) begin
      err_c = 1 + TO;
    end else begin
      enc_done_c = 1 + e;
      crc0 = 2 + e;
      if (c > TO - 1) err_c = crc0 + TO;
      else begin
        crc_done_c = crc0 + c; load_c = crc_done_c + 1; send_c = load_c + 1;
        tx_c = send_c + t; done_c = tx_c + 1;
      end
    end
    endc = (err_c >= 0) ? err_c : done_c;

    clear_inputs();
    start = 1'b1; pkt_type = ty; pid_in = pid; ack_rx = ack_with;
    if (ack_with) model_toggle = ~model_toggle;
    enc_done = (enc_done_c == 0);
    tick();
    for (int i = 1; i <= endc; i++) begin
      clear_inputs();
      sel_on = is_data ? (crc0 >= 0 && i >= crc0) : 1'b1;
      ev = {i < endc, is_data && i == 1, i == crc0, i == load_c, i == done_c, i == err_c,
            (i < endc && sel_on) ? exp_sel : SEL_IDLE};
      check($sformatf("cycle %0d outputs", i), 32'(obs()), 32'(ev));
      if (i == 1) check("pid_out", 32'(pid_out), 32'(exp_pid));
      if (i == load_c) check("byte_count at load", 32'(byte_count), 32'(exp_bytes));
      if (i == endc) break;
      enc_done = (i == enc_done_c);
      crc_done = (i == crc_done_c);
      tx_done  = (i == tx_c);
      in_enc  = is_data && i <= ((enc_done_c >= 0) ? enc_done_c : err_c - 1);
      in_crc  = crc0 >= 0 && i >= crc0 && i <= ((crc_done_c >= 0) ? crc_done_c : err_c - 1);
      in_send = send_c >= 0 && i >= send_c && i <= tx_c;
      if (noise) begin
        if ($urandom_range(0, 5) == 0) begin ack_rx = 1'b1; model_toggle = ~model_toggle; end
        if ($urandom_range(0, 4) == 0) begin start = 1'b1; pkt_type = 2'($urandom_range(0, 3)); end
        if (!in_enc  && $urandom_range(0, 3) == 0) enc_done = 1'b1;
        if (!in_crc  && $urandom_range(0, 3) == 0) crc_done = 1'b1;
        if (!in_send && $urandom_range(0, 3) == 0) tx_done  = 1'b1;
      end
      if (stray_sof && i == send_c) begin
        start = 1'b1; pkt_type = 2'd3; pid_in = PID_SOF;
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           ty     pid    e   c  t ack sof gap gack exp_pid    bytes  sel
    tbl[0]  = '{2'd2, PID_ACK, 0,  0, 2, 0, 0,  1, 0, PID_ACK,   4'd1,  SEL_HANDSHAKE};
    tbl[1]  = '{2'd1, 8'h00,   5,  7, 1, 0, 0,  2, 1, PID_DATA0, 4'd11, SEL_DATA};
    tbl[2]  = '{2'd1, 8'h00,   2,  3, 0, 0, 0,  1, 0, PID_DATA1, 4'd11, SEL_DATA};
    tbl[3]  = '{2'd1, 8'h00,   1,  1, 2, 1, 0,  0, 0, PID_DATA0, 4'd11, SEL_DATA};
    tbl[4]  = '{2'd1, 8'h00,  20,  0, 0, 0, 0,  0, 0, PID_DATA0, 4'd11, SEL_DATA};
    tbl[5]  = '{2'd1, 8'h00,   0,  0, 0, 0, 0,  1, 0, PID_DATA0, 4'd11, SEL_DATA};
    tbl[6]  = '{2'd0, 8'hE1,   0,  0, 1, 0, 0,  1, 0, 8'hE1,     4'd3,  SEL_TOKEN};
    tbl[7]  = '{2'd3, PID_SOF, 0,  0, 3, 0, 1,  1, 0, PID_SOF,   4'd3,  SEL_SOF};
    tbl[8]  = '{2'd1, 8'h00,   2,  9, 0, 0, 0,  1, 0, PID_DATA0, 4'd11, SEL_DATA};
    tbl[9]  = '{2'd1, 8'h00,   7,  0, 0, 0, 0,  0, 0, PID_DATA0, 4'd11, SEL_DATA};
    tbl[10] = '{2'd1, 8'h00,   8,  0, 0, 0, 0,  1, 0, PID_DATA0, 4'd11, SEL_DATA};
    tbl[11] = '{2'd2, PID_NAK, 0,  0, 0, 0, 0,  1, 0, PID_NAK,   4'd1,  SEL_HANDSHAKE};

    // Reset state
    #2;
    check("reset outputs", 32'(obs()), 32'({6'b0, SEL_IDLE}));
    check("reset pid_out", 32'(pid_out), 32'h00);
    check("reset byte_count", 32'(byte_count), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post-reset idle", 32'(obs()), 32'({6'b0, SEL_IDLE}));

    for (int v = 0; v < 12; v++) begin
      run_packet(tbl[v].ty, tbl[v].pid, tbl[v].e, tbl[v].c, tbl[v].t, tbl[v].ack_with, 1'b0,
                 tbl[v].stray_sof, tbl[v].exp_pid, tbl[v].exp_bytes, tbl[v].exp_sel);
      idle(tbl[v].gap, tbl[v].gap_ack);
    end

    // Stray done strobes in IDLE must not move the block.
    idle(1, 1'b0);
    enc_done = 1'b1; crc_done = 1'b1; tx_done = 1'b1;
    tick();
    clear_inputs();
    check("stray strobes in idle", 32'(obs()), 32'({6'b0, SEL_IDLE}));

    // Toggle to 1, then reset mid-CRC: outputs drop at once, toggle returns to 0.
    idle(1, 1'b1);
    start = 1'b1; pkt_type = 2'd1;
    tick();
    clear_inputs();
    enc_done = 1'b1;
    tick();
    clear_inputs();
    tick();
    check("in CRC before reset", 32'(obs()), 32'({6'b100000, SEL_DATA}));
    check("pid before reset", 32'(pid_out), 32'(PID_DATA1));
    #2 rst = 1'b0;
    #1;
    check("async reset outputs", 32'(obs()), 32'({6'b0, SEL_IDLE}));
    check("async reset pid_out", 32'(pid_out), 32'h00);
    check("async reset byte_count", 32'(byte_count), 32'h0);
    model_toggle = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(2, 1'b0);
    run_packet(2'd1, 8'h00, 1, 2, 1, 1'b0, 1'b0, 1'b0, PID_DATA0, 4'd11, SEL_DATA);
    idle(1, 1'b0);

    // Randomized packets against the timeline/toggle model.
    for (int n = 0; n < 40; n++) begin
      logic [1:0] ty;
      logic [7:0] pid, ep;
      logic [3:0] eb;
      bit aw;
      int gap;
      ty  = 2'($urandom_range(0, 3));
      pid = 8'($urandom_range(0, 255));
      aw  = ($urandom_range(0, 3) == 0);
      ep  = (ty == 2'd1) ? (((model_toggle ^ aw) != 0) ? PID_DATA1 : PID_DATA0) : pid;
      eb  = (ty == 2'd1) ? 4'd11 : (ty == 2'd2) ? 4'd1 : 4'd3;
      run_packet(ty, pid, $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 4),
                 aw, 1'b1, 1'b0, ep, eb, {1'b0, ty});
      gap = $urandom_range(0, 2);
      idle(gap, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
